// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Receive side of a multiplexed 8-digit seven-segment bus. The block watches
//   the active-low anode strobes and active-low segment lines and decodes each
//   stable digit back to a hex nibble. Once all eight digits have been seen, it
//   publishes the reassembled 32-bit word. Digit i (an[i] low) maps to x[4i+3:4i].
//
//   Parameter
//     SETTLE_CYCLES  stable-sample count before a digit is accepted (1..255)
//
//   Ports
//     clk          system clock, rising edge
//     clr          asynchronous active-high reset
//     an[7:0]      anode strobes, active-low (one-hot-low or all ones)
//     a_to_g[6:0]  segment lines, active-low, bit order gfedcba
//     dp           decimal point, ignored
//     x[31:0]      last complete reassembled frame
//     frame_valid  one-cycle pulse when x is updated
//     digit_seen   digits captured since the last completed frame
//     err[1:0]     sticky: bit0 unknown segment pattern, bit1 illegal anode code
//
//   Build option
//     SEG7_SYNC_EN  when defined, an/a_to_g pass through a 2-flop synchronizer
//                   (reset to all ones) and every latency grows by 2 cycles.
module seg7_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  an,
  input  logic [6:0]  a_to_g,
  input  logic        dp,
  output logic [31:0] x,
  output logic        frame_valid,
  output logic [7:0]  digit_seen,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] CNT_TOP  = 8'(SETTLE_CYCLES);

  logic [14:0] bus;
  logic [7:0]  an_s;
  logic [6:0]  seg_s;
  logic [14:0] smp;
  logic [7:0]  cnt;
  logic [31:0] shadow;
  state_t      state, state_nx;
  logic        stable, hot, idle_code, illegal;
  logic        capture;
  logic        known;
  logic [3:0]  nib;
  logic [7:0]  seen_nx;
  logic        unused;

  assign unused = dp;

`ifdef SEG7_SYNC_EN
  logic [14:0] sync1, sync2;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an, a_to_g};
      sync2 <= sync1;
    end
  end

  assign bus = sync2;
`else
  assign bus = {an, a_to_g};
`endif

  assign an_s      = bus[14:7];
  assign seg_s     = bus[6:0];
  assign stable    = (smp == bus);
  assign hot       = $onehot(~an_s);
  assign idle_code = (an_s == 8'hFF);
  assign illegal   = !hot && !idle_code;

  always_comb begin
    nib   = '0;
    known = 1'b1;
    case (seg_s)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0111111: nib = 4'hA;
      7'b1111111: nib = 4'hB;
      7'b1110111: nib = 4'hC;
      default:    known = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    if (illegal) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (hot) state_nx = SETTLE;
        SETTLE: begin
          if (idle_code)                        state_nx = IDLE;
          else if (stable && cnt == CNT_LAST)   state_nx = HELD;
        end
        HELD:    if (!stable) state_nx = idle_code ? IDLE : SETTLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM: outputs. HELD blocks a second capture for the same dwell.
  always_comb begin
    capture = 1'b0;
    if (state == SETTLE && hot && stable && cnt == CNT_LAST)
      capture = 1'b1;
  end

  // A completed frame clears digit_seen on the publishing cycle
  always_comb begin
    seen_nx = (digit_seen == 8'hFF) ? 8'h00 : digit_seen;
    if (capture && known)
      seen_nx = seen_nx | ~an_s;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      smp         <= '1;
      cnt         <= '0;
      shadow      <= '0;
      x           <= '0;
      frame_valid <= 1'b0;
      digit_seen  <= '0;
      err         <= '0;
    end else begin
      smp <= bus;
      if (!stable)              cnt <= '0;
      else if (cnt != CNT_TOP)  cnt <= cnt + 8'd1;

      for (int unsigned i = 0; i < 8; i++) begin
        if (capture && known && !an_s[i])
          shadow[4*i +: 4] <= nib;
      end

      frame_valid <= 1'b0;
      if (digit_seen == 8'hFF) begin
        x           <= shadow;
        frame_valid <= 1'b1;
      end
      digit_seen <= seen_nx;

      err <= err | {illegal, capture && !known};
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: stimulus tasks push expected frames
// into a scoreboard queue; a monitor pops and checks on every frame_valid.
module tb_seg7_scan_decoder;

  localparam int S = 4;
`ifdef SEG7_SYNC_EN
  localparam int LAT = S + 4;
`else
  localparam int LAT = S + 2;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  an_i;
  logic [6:0]  seg_i;
  logic        dp_i = 1'b0;
  logic [31:0] x;
  logic        frame_valid;
  logic [7:0]  digit_seen;
  logic [1:0]  err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] x;
    int          due;
  } exp_t;
  exp_t sb[$];

  seg7_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .clr         (clr),
    .an          (an_i),
    .a_to_g      (seg_i),
    .dp          (dp_i),
    .x           (x),
    .frame_valid (frame_valid),
    .digit_seen  (digit_seen),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0111111;
      4'hB: enc = 7'b1111111;
      4'hC: enc = 7'b1110111;
      default: enc = 7'b1010101;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the bus value across n rising edges.
  task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
    an_i  = a;
    seg_i = s;
    repeat (n) @(negedge clk);
  endtask

  // Sends the digits selected by mask in order 0..7, 10 cycles each.
  task automatic send(input logic [31:0] value, input logic [7:0] mask, input bit push);
    int   last = 0;
    exp_t e;
    for (int i = 0; i < 8; i++) if (mask[i]) last = i;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (push && i == last) begin
          e.x   = value;
          e.due = cyc + LAT;
          sb.push_back(e);
        end
        hold(~(8'h01 << i), enc(value[4*i +: 4]), 10);
      end
    end
    hold(8'hFF, 7'h7F, 4);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr === 1'b0 && frame_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got x=%h expected no frame", x);
        end else begin
          e = sb.pop_front();
          check("frame_x", x, e.x);
          check("frame_latency", cyc, e.due);
          check("seen_after_frame", {24'h0, digit_seen}, 32'h0);
        end
      end
    end
  end

  initial begin
    clr   = 1'b1;
    an_i  = 8'hFF;
    seg_i = 7'h7F;
    repeat (3) @(negedge clk);
    clr = 1'b0;

    // Dirty the state, then reset asynchronously between clock edges
    hold(8'hFE, enc(4'h3), 8);
    hold(8'hFC, enc(4'h3), 5);
    check("pre_reset_seen", {24'h0, digit_seen}, 32'h01);
    check("pre_reset_err", {30'h0, err}, 32'h2);
    an_i = 8'hFF;
    #2 clr = 1'b1;
    #1;
    check("rst_x", x, 32'h0);
    check("rst_fv", {31'h0, frame_valid}, 32'h0);
    check("rst_seen", {24'h0, digit_seen}, 32'h0);
    check("rst_err", {30'h0, err}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    hold(8'hFF, 7'h7F, 3);

    // Full frame
    send(32'h2468ACB9, 8'hFF, 1'b1);
    check("full_seen", {24'h0, digit_seen}, 32'h0);
    check("full_err", {30'h0, err}, 32'h0);

    // Glitch rejection: 3-cycle "2" then "1"
    hold(8'hFE, enc(4'h2), 3);
    hold(8'hFE, enc(4'h1), 6);
    hold(8'hFF, 7'h7F, 4);
    check("glitch_seen", {24'h0, digit_seen}, 32'h01);
    // Dwell of S samples is one short; S+1 captures
    hold(8'hEF, enc(4'hC), S);
    hold(8'hFF, 7'h7F, 4);
    check("short_dwell", {24'h0, digit_seen}, 32'h01);
    hold(8'hEF, enc(4'hC), S + 1);
    hold(8'hFF, 7'h7F, 4);
    check("exact_dwell", {24'h0, digit_seen}, 32'h11);
    send(32'h1B0C9721, 8'hEE, 1'b1);

    // Unknown segment pattern
    hold(8'hFB, 7'b1010101, 8);
    hold(8'hFF, 7'h7F, 4);
    check("unk_err", {30'h0, err}, 32'h1);
    check("unk_seen", {24'h0, digit_seen}, 32'h0);
    hold(8'hFB, enc(4'hA), 8);
    hold(8'hFF, 7'h7F, 4);
    check("unk_recover_seen", {24'h0, digit_seen}, 32'h04);
    check("unk_sticky", {30'h0, err}, 32'h1);
    send(32'h12340A56, 8'hFB, 1'b1);

    // Illegal anode code
    hold(8'hFC, enc(4'h5), 5);
    hold(8'hFF, 7'h7F, 4);
    check("ill_err", {30'h0, err}, 32'h3);
    check("ill_seen", {24'h0, digit_seen}, 32'h0);
    send(32'h0C1B2A39, 8'hFF, 1'b1);

    // Overwrite of digit 3
    send(32'h98765432, 8'h0F, 1'b0);
    hold(8'hF7, enc(4'h7), 10);
    hold(8'hFF, 7'h7F, 4);
    check("ovw_seen", {24'h0, digit_seen}, 32'h0F);
    send(32'h98767432, 8'hF0, 1'b1);

    // Reset mid-frame discards partial frame
    send(32'h11112222, 8'h0F, 1'b0);
    check("mid_seen", {24'h0, digit_seen}, 32'h0F);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("mid_rst_seen", {24'h0, digit_seen}, 32'h0);
    send(32'h11112222, 8'hF0, 1'b0);
    hold(8'hFF, 7'h7F, 10);
    check("mid_upper_seen", {24'h0, digit_seen}, 32'hF0);
    send(32'h11111234, 8'h0F, 1'b1);

    hold(8'hFF, 7'h7F, 10);
    check("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
